rf_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources: the main datapath (port A, fixed one-per-cycle writebacks) and the multi-cycle unit (port B, multiply/divide or memory return). Registers the granted write for one cycle before driving the regfile write port, and keeps a pending-write scoreboard so the hazard logic can stall reads of registers with an outstanding port-B result. It sits between the writeback stage and `regfile`.

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 36 +++
 rtl/rf_write_arbiter.sv | 64 ++++++
 tb/tb_rf_write_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: register file geometry and the captured write record shared by the write arbiter.
package rf_pkg;
   localparam int RF_AW   = 5;
   localparam int RF_DW   = 32;
   localparam int RF_NREG = 32;
   typedef struct packed {
      logic             we;
      logic [RF_AW-1:0] wn;
      logic [RF_DW-1:0] data;
   } rf_wr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write bits for outstanding port-B results plus a sticky double-issue error.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                set_v_i,
   input  logic [RF_AW-1:0]    set_wn_i,
   input  logic                clr_v_i,
   input  logic [RF_AW-1:0]    clr_wn_i,
   output logic [RF_NREG-1:0]  pending_o,
   output logic                issue_err_o
);
   logic [RF_NREG-1:0] pend_q, pend_d;
   logic               err_q, err_d;
   logic               set_ok;
   assign set_ok = set_v_i && (set_wn_i != '0);
   always_comb begin
      pend_d = pend_q;
      if (clr_v_i) pend_d[clr_wn_i] = 1'b0;
      // applied after the clear so a same-edge reissue keeps the bit set
      if (set_ok) pend_d[set_wn_i] = 1'b1;
      err_d = err_q | (set_ok && pend_q[set_wn_i] && !(clr_v_i && clr_wn_i == set_wn_i));
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end
   assign pending_o   = pend_q;
   assign issue_err_o = err_q;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the regfile write port between datapath (A) and multi-cycle unit (B),
// with starvation override for B, a registered write stage and a pending-write scoreboard.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int STARVE_LIMIT = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                a_valid,
   input  logic [RF_AW-1:0]    a_wn,
   input  logic [RF_DW-1:0]    a_data,
   output logic                a_ready,
   input  logic                b_valid,
   input  logic [RF_AW-1:0]    b_wn,
   input  logic [RF_DW-1:0]    b_data,
   output logic                b_ready,
   input  logic                b_issue,
   input  logic [RF_AW-1:0]    b_issue_wn,
   output logic                rf_we,
   output logic [RF_AW-1:0]    rf_wn,
   output logic [RF_DW-1:0]    rf_data,
   output logic [RF_NREG-1:0]  pending,
   output logic                issue_err
);
   localparam int CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
   logic [CW-1:0] starve_q, starve_d;
   rf_wr_t        wr_q, wr_d;
   logic          b_win, a_xfer, b_xfer;
   assign b_win   = b_valid && (!a_valid || starve_q == LIM);
   assign a_ready = reset && a_valid && !b_win;
   assign b_ready = reset && b_win;
   assign a_xfer  = a_valid && a_ready;
   assign b_xfer  = b_valid && b_ready;
   assign starve_d = (b_valid && !b_ready) ? ((starve_q == LIM) ? starve_q : starve_q + CW'(1)) : '0;
   always_comb begin
      wr_d = '{we: 1'b0, wn: wr_q.wn, data: wr_q.data};
      if (a_xfer) wr_d = '{we: (a_wn != '0), wn: a_wn, data: a_data};
      else if (b_xfer) wr_d = '{we: (b_wn != '0), wn: b_wn, data: b_data};
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starve_q <= '0;
         wr_q     <= '0;
      end else begin
         starve_q <= starve_d;
         wr_q     <= wr_d;
      end
   end
   assign rf_we   = wr_q.we;
   assign rf_wn   = wr_q.wn;
   assign rf_data = wr_q.data;
   rf_scoreboard u_sb (
      .clock       (clock),
      .reset       (reset),
      .set_v_i     (b_issue),
      .set_wn_i    (b_issue_wn),
      .clr_v_i     (b_xfer),
      .clr_wn_i    (b_wn),
      .pending_o   (pending),
      .issue_err_o (issue_err)
   );
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed plan steps then random traffic, checked against a behavioural model.
module tb_rf_write_arbiter;
   logic        clock = 1'b0, reset = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0, b_issue = 1'b0;
   logic [4:0]  a_wn = '0, b_wn = '0, b_issue_wn = '0;
   logic [31:0] a_data = '0, b_data = '0;
   logic        a_ready, b_ready, rf_we, issue_err;
   logic [4:0]  rf_wn;
   logic [31:0] rf_data, pending;
   int tests = 0, fails = 0;
   int          ms;
   bit          mwe, merr;
   bit [4:0]    mwn;
   bit [31:0]   mdata, mp;
   logic        got_a, got_b;

   rf_write_arbiter #(.STARVE_LIMIT(3)) dut (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_wn(a_wn), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_wn(b_wn), .b_data(b_data), .b_ready(b_ready),
      .b_issue(b_issue), .b_issue_wn(b_issue_wn),
      .rf_we(rf_we), .rf_wn(rf_wn), .rf_data(rf_data),
      .pending(pending), .issue_err(issue_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ms = 0; mwe = 0; merr = 0; mwn = '0; mdata = '0; mp = '0;
   endtask

   // one clock: drive inputs, check grant, advance the model, check registered outputs
   task automatic cyc(input logic av, input logic [4:0] aw, input logic [31:0] ad,
                      input logic bv, input logic [4:0] bw, input logic [31:0] bd,
                      input logic bi, input logic [4:0] biw);
      bit ga, gb;
      a_valid = av; a_wn = aw; a_data = ad;
      b_valid = bv; b_wn = bw; b_data = bd;
      b_issue = bi; b_issue_wn = biw;
      #1;
      gb = bv && (!av || ms >= 3);
      ga = av && !gb;
      got_a = a_ready; got_b = b_ready;
      chk("a_ready", {31'd0, a_ready}, {31'd0, ga});
      chk("b_ready", {31'd0, b_ready}, {31'd0, gb});
      if (ga) begin mwe = (aw != 0); mwn = aw; mdata = ad; end
      else if (gb) begin mwe = (bw != 0); mwn = bw; mdata = bd; end
      else mwe = 0;
      ms = (bv && !gb) ? ((ms + 1 > 3) ? 3 : ms + 1) : 0;
      if (bi && biw != 0 && mp[biw] && !(gb && bw == biw)) merr = 1;
      if (gb) mp[bw] = 1'b0;
      if (bi && biw != 0) mp[biw] = 1'b1;
      @(posedge clock); #1;
      chk("rf_we", {31'd0, rf_we}, {31'd0, mwe});
      chk("rf_wn", {27'd0, rf_wn}, {27'd0, mwn});
      chk("rf_data", rf_data, mdata);
      chk("pending", pending, mp);
      chk("issue_err", {31'd0, issue_err}, {31'd0, merr});
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_we", {31'd0, rf_we}, 32'd0);
      chk("rst_pending", pending, 32'd0);
      chk("rst_b_ready_gated", {31'd0, b_ready}, 32'd0);
      reset = 1'b1;
      // A only
      cyc(1, 5, 32'h1234, 0, 0, 0, 0, 0);
      chk("aonly_we", {31'd0, rf_we}, 32'd1);
      chk("aonly_wn", {27'd0, rf_wn}, 32'd5);
      chk("aonly_data", rf_data, 32'h1234);
      idle();
      chk("aonly_idle_we", {31'd0, rf_we}, 32'd0);
      chk("aonly_hold_data", rf_data, 32'h1234);
      // starvation: A,A,A,B,A
      for (int i = 0; i < 5; i++) begin
         cyc(1, 5'(i + 1), 32'(i), 1, 5'd10, 32'hB0B0, 0, 0);
         chk("starve_b_grant", {31'd0, got_b}, {31'd0, (i == 3)});
      end
      idle();
      // scoreboard set then B clear
      cyc(0, 0, 0, 0, 0, 0, 1, 9);
      chk("sb_set", pending, 32'h200);
      cyc(0, 0, 0, 1, 9, 32'hBEEF, 0, 0);
      chk("sb_clr", pending, 32'h0);
      chk("sb_wn", {27'd0, rf_wn}, 32'd9);
      chk("sb_data", rf_data, 32'hBEEF);
      // register 0
      cyc(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
      chk("r0_ready", {31'd0, got_a}, 32'd1);
      chk("r0_we", {31'd0, rf_we}, 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      chk("r0_pending", pending, 32'h0);
      // collision: same-edge set and clear keeps the bit, no error
      cyc(0, 0, 0, 0, 0, 0, 1, 7);
      cyc(0, 0, 0, 1, 7, 32'h77, 1, 7);
      chk("coll_pending", pending, 32'h80);
      chk("coll_err", {31'd0, issue_err}, 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 1, 7);
      chk("dbl_err", {31'd0, issue_err}, 32'd1);
      idle(); idle();
      chk("err_sticky", {31'd0, issue_err}, 32'd1);
      cyc(1, 3, 32'h55, 0, 0, 0, 0, 0);
      chk("pre_rst_we", {31'd0, rf_we}, 32'd1);
      chk("pre_rst_pending", pending, 32'h80);
      // asynchronous reset between edges
      #2 reset = 1'b0;
      #1;
      chk("arst_we", {31'd0, rf_we}, 32'd0);
      chk("arst_wn", {27'd0, rf_wn}, 32'd0);
      chk("arst_data", rf_data, 32'd0);
      chk("arst_pending", pending, 32'd0);
      chk("arst_err", {31'd0, issue_err}, 32'd0);
      chk("arst_a_ready", {31'd0, a_ready}, 32'd0);
      model_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      // random traffic with a narrow register range to provoke collisions
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
